// File: rtl/note_sequence_game_pkg.sv
// Shared state encoding, display codes and LFSR step for the memory-tone game.
package note_sequence_game_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_TONE,
        S_GAP,
        S_WAIT_KEY,
        S_WAIT_REL,
        S_PASS,
        S_FAIL
    } state_e;

    localparam logic [1:0] DISP_STAY = 2'd0;
    localparam logic [1:0] DISP_PLAY = 2'd1;
    localparam logic [1:0] DISP_PASS = 2'd2;
    localparam logic [1:0] DISP_FAIL = 2'd3;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Fibonacci step, taps 16,14,13,11; maximal length so a nonzero seed never reaches 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/note_sequence_game_lfsr16.sv
// Free-running 16-bit LFSR note source; reseeds on reset.
module lfsr16
    import note_sequence_game_pkg::*;
(
    input  logic        clk,
    input  logic        nrst,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            q <= LFSR_SEED;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/note_sequence_game.sv
// Memory-tone game core: grows a random note sequence, replays it, then checks the
// player's presses in order, with per-press timeout, level count and win pulse.
module note_sequence_game
    import note_sequence_game_pkg::*;
#(
    parameter int unsigned FRQ         = 1_000_000,
    parameter int unsigned NKEYS       = 8,
    parameter int unsigned MAX_LEN     = 8,
    parameter int unsigned TONE_CYC    = FRQ / 2,
    parameter int unsigned GAP_CYC     = FRQ / 8,
    parameter int unsigned RESULT_CYC  = FRQ,
    parameter int unsigned TIMEOUT_CYC = 5 * FRQ,
    parameter int unsigned START_KEY   = 4
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic [NKEYS-1:0]               key,
    output logic [$clog2(NKEYS)-1:0]       octave,
    output logic                           piezo_nOn,
    output logic [1:0]                     display,
    output logic [$clog2(MAX_LEN+1)-1:0]   level,
    output logic                           win
);

    localparam int NW  = $clog2(NKEYS);
    localparam int LVW = $clog2(MAX_LEN + 1);
    localparam int IW  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [31:0]    TONE_LAST    = 32'(TONE_CYC - 1);
    localparam logic [31:0]    GAP_LAST     = 32'(GAP_CYC - 1);
    localparam logic [31:0]    RESULT_LAST  = 32'(RESULT_CYC - 1);
    localparam logic [31:0]    TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
    localparam logic [LVW-1:0] LEVEL_WIN    = LVW'(MAX_LEN);

    logic [15:0]      lfsr_q;
    logic [15-NW:0]   lfsr_unused;
    logic [NW-1:0]    note;

    state_e           state_q;
    logic [31:0]      cnt_q;
    logic [LVW-1:0]   level_q;
    logic [LVW-1:0]   idx_q;
    logic [NW-1:0]    octave_q;
    logic             piezo_q;
    logic [1:0]       disp_q;
    logic             win_q;
    logic [NW-1:0]    seq_q [2**IW];

    logic [LVW-1:0]   idx_inc;
    logic [NW-1:0]    cur_note;

    lfsr16 u_lfsr (
        .clk  (clk),
        .nrst (nrst),
        .q    (lfsr_q)
    );

    assign {lfsr_unused, note} = lfsr_q;
    assign idx_inc  = idx_q + LVW'(1);
    assign cur_note = seq_q[idx_q[IW-1:0]];

    // Sequence storage is always written in GEN before any replay reads it.
    always_ff @(posedge clk) begin
        if (state_q == S_GEN) begin
            seq_q[level_q[IW-1:0]] <= note;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            level_q  <= '0;
            idx_q    <= '0;
            octave_q <= '0;
            piezo_q  <= 1'b1;
            disp_q   <= DISP_STAY;
            win_q    <= 1'b0;
        end else begin
            win_q <= 1'b0;
            cnt_q <= cnt_q + 32'd1;
            case (state_q)
                S_IDLE: begin
                    if (key[START_KEY]) begin
                        level_q <= '0;
                        disp_q  <= DISP_PLAY;
                        cnt_q   <= '0;
                        state_q <= S_GEN;
                    end
                end
                S_GEN: begin
                    // The new note is written this same edge, so bypass it for a first-round replay.
                    level_q  <= level_q + LVW'(1);
                    idx_q    <= '0;
                    octave_q <= (level_q == '0) ? note : seq_q[0];
                    piezo_q  <= 1'b0;
                    disp_q   <= DISP_PLAY;
                    cnt_q    <= '0;
                    state_q  <= S_TONE;
                end
                S_TONE: begin
                    if (cnt_q == TONE_LAST) begin
                        piezo_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q <= '0;
                        if (idx_inc == level_q) begin
                            idx_q   <= '0;
                            state_q <= S_WAIT_KEY;
                        end else begin
                            idx_q    <= idx_inc;
                            octave_q <= seq_q[idx_inc[IW-1:0]];
                            piezo_q  <= 1'b0;
                            state_q  <= S_TONE;
                        end
                    end
                end
                S_WAIT_KEY: begin
                    // Exact one-hot match rejects both wrong keys and chords.
                    if (key != '0) begin
                        cnt_q <= '0;
                        if (key == (NKEYS'(1) << cur_note)) begin
                            state_q <= S_WAIT_REL;
                        end else begin
                            disp_q  <= DISP_FAIL;
                            state_q <= S_FAIL;
                        end
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_q   <= '0;
                        disp_q  <= DISP_FAIL;
                        state_q <= S_FAIL;
                    end
                end
                S_WAIT_REL: begin
                    if (key == '0) begin
                        cnt_q <= '0;
                        if (idx_inc == level_q) begin
                            disp_q  <= DISP_PASS;
                            win_q   <= (level_q == LEVEL_WIN);
                            state_q <= S_PASS;
                        end else begin
                            idx_q   <= idx_inc;
                            state_q <= S_WAIT_KEY;
                        end
                    end
                end
                S_PASS: begin
                    if (cnt_q == RESULT_LAST) begin
                        cnt_q <= '0;
                        if (level_q == LEVEL_WIN) begin
                            disp_q  <= DISP_STAY;
                            state_q <= S_IDLE;
                        end else begin
                            disp_q  <= DISP_PLAY;
                            state_q <= S_GEN;
                        end
                    end
                end
                S_FAIL: begin
                    if (cnt_q == RESULT_LAST) begin
                        cnt_q   <= '0;
                        disp_q  <= DISP_STAY;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign octave    = octave_q;
    assign piezo_nOn = piezo_q;
    assign display   = disp_q;
    assign level     = level_q;
    assign win       = win_q;

endmodule

// File: tb/tb_note_sequence_game.sv
// Randomized bench for note_sequence_game against a sequence/phase reference model.
module tb_note_sequence_game;

    localparam int NKEYS     = 8;
    localparam int MAX_LEN   = 3;
    localparam int TONE      = 10;
    localparam int GAP       = 4;
    localparam int RESULT    = 20;
    localparam int TIMEOUT   = 50;
    localparam int START_KEY = 4;

    logic             clk = 1'b0;
    logic             nrst;
    logic [NKEYS-1:0] key;
    logic [2:0]       octave;
    logic             piezo_nOn;
    logic [1:0]       display;
    logic [1:0]       level;
    logic             win;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_lfsr = 16'hACE1;
    int          mseq[$];

    note_sequence_game #(
        .FRQ         (100),
        .NKEYS       (NKEYS),
        .MAX_LEN     (MAX_LEN),
        .TONE_CYC    (TONE),
        .GAP_CYC     (GAP),
        .RESULT_CYC  (RESULT),
        .TIMEOUT_CYC (TIMEOUT),
        .START_KEY   (START_KEY)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .key       (key),
        .octave    (octave),
        .piezo_nOn (piezo_nOn),
        .display   (display),
        .level     (level),
        .win       (win)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_model(input logic [15:0] s);
        int   taps[4] = '{16, 14, 13, 11};
        logic fb = 1'b0;
        foreach (taps[t]) fb ^= s[taps[t] - 1];
        return {s[14:0], fb};
    endfunction

    // Reference note source: advances every clock, reseeded whenever reset is sampled.
    always @(posedge clk) m_lfsr <= nrst ? lfsr_model(m_lfsr) : 16'hACE1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input int disp, input int pz, input int lvl, input int w);
        check({tag, ".display"}, 32'(display), 32'(disp));
        check({tag, ".piezo_nOn"}, 32'(piezo_nOn), 32'(pz));
        check({tag, ".level"}, 32'(level), 32'(lvl));
        check({tag, ".win"}, 32'(win), 32'(w));
    endtask

    task automatic idle(input int n, input int lvl);
        repeat (n) begin
            @(negedge clk);
            expect_out("idle", 0, 1, lvl, 0);
        end
    endtask

    task automatic do_reset(input string tag);
        nrst = 1'b0;
        @(negedge clk);
        expect_out(tag, 0, 1, 0, 0);
        check({tag, ".octave"}, 32'(octave), 32'd0);
        nrst = 1'b1;
        mseq.delete();
    endtask

    task automatic gen_cycle();
        expect_out("gen", 1, 1, mseq.size(), 0);
        mseq.push_back(int'(m_lfsr[2:0]));
    endtask

    task automatic start_game(input bit hold);
        mseq.delete();
        key = NKEYS'(1 << START_KEY);
        @(negedge clk);
        gen_cycle();
        if (!hold) key = '0;
    endtask

    task automatic playback(input bit noisy);
        foreach (mseq[i]) begin
            repeat (TONE) begin
                @(negedge clk);
                expect_out("tone", 1, 0, mseq.size(), 0);
                check("tone.octave", 32'(octave), 32'(mseq[i]));
                key = noisy ? NKEYS'($urandom) : '0;
            end
            repeat (GAP) begin
                @(negedge clk);
                expect_out("gap", 1, 1, mseq.size(), 0);
                key = '0;
            end
        end
    endtask

    task automatic press_correct(input int count);
        for (int j = 0; j < count; j++) begin
            repeat ($urandom_range(1, 4)) begin
                @(negedge clk);
                expect_out("wait", 1, 1, mseq.size(), 0);
            end
            key = NKEYS'(1 << mseq[j]);
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                expect_out("held", 1, 1, mseq.size(), 0);
            end
            key = '0;
        end
    endtask

    task automatic bad_press(input int j, input bit chord);
        int w;
        w = (mseq[j] + int'($urandom_range(1, NKEYS - 1))) % NKEYS;
        repeat ($urandom_range(1, 4)) begin
            @(negedge clk);
            expect_out("wait", 1, 1, mseq.size(), 0);
        end
        key = chord ? NKEYS'((1 << mseq[j]) | (1 << w)) : NKEYS'(1 << w);
    endtask

    task automatic expect_pass();
        int n = mseq.size();
        @(negedge clk);
        expect_out("pass.entry", 2, 1, n, (n == MAX_LEN) ? 1 : 0);
        repeat (RESULT - 1) begin
            @(negedge clk);
            expect_out("pass", 2, 1, n, 0);
            key = NKEYS'($urandom);
        end
        key = '0;
        @(negedge clk);
        if (n == MAX_LEN) expect_out("idle.after_win", 0, 1, n, 0);
        else gen_cycle();
    endtask

    task automatic expect_fail(input int lvl);
        repeat (RESULT) begin
            @(negedge clk);
            expect_out("fail", 3, 1, lvl, 0);
            key = NKEYS'($urandom);
        end
        key = '0;
        @(negedge clk);
        expect_out("idle.after_fail", 0, 1, lvl, 0);
    endtask

    task automatic win_game(input bit noisy);
        start_game(noisy);
        for (int r = 1; r <= MAX_LEN; r++) begin
            playback(noisy && (r != 1));
            press_correct(r);
            expect_pass();
        end
        idle(5, MAX_LEN);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        nrst = 1'b0;
        key  = '0;
        do_reset("reset");
        idle(100, 0);

        win_game(1'b0);

        // Wrong key on the second press of round 2.
        idle($urandom_range(1, 20), MAX_LEN);
        start_game(1'b1);
        playback(1'b0);
        press_correct(1);
        expect_pass();
        playback(1'b1);
        press_correct(1);
        bad_press(1, 1'b0);
        expect_fail(2);

        // Chord containing the right key, then a silent timeout.
        idle(3, 2);
        start_game(1'b0);
        playback(1'b0);
        bad_press(0, 1'b1);
        expect_fail(1);
        idle(2, 1);
        start_game(1'b0);
        playback(1'b0);
        repeat (TIMEOUT) begin
            @(negedge clk);
            expect_out("wait.timeout", 1, 1, 1, 0);
        end
        expect_fail(1);

        // Reset mid-tone and mid-PASS.
        idle(2, 1);
        start_game(1'b0);
        repeat (5) begin
            @(negedge clk);
            expect_out("tone", 1, 0, 1, 0);
        end
        do_reset("rst.tone");
        idle(5, 0);
        start_game(1'b0);
        playback(1'b0);
        press_correct(1);
        @(negedge clk);
        expect_out("pass.entry", 2, 1, 1, 0);
        repeat (7) @(negedge clk);
        do_reset("rst.pass");
        idle(5, 0);

        win_game(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
